// File: rtl/ps2_command_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, 11-clock frame, ACK check.
// Drives the open-drain lines through *_drive_low outputs; completion and failure reported as 1-cycle pulses.
//
// state        | meaning
// IDLE         | lines released, waiting for send_command
// INHIBIT      | PS2_CLK held low for CLK_INHIBIT_CYCLES
// RTS          | one cycle with both lines low (request-to-send)
// WAIT_FIRST   | clk released, start bit on dat, waiting for the device's first falling edge
// SHIFT        | driving data, parity and stop bits on successive falling edges
// WAIT_ACK     | stop bit sent, waiting for the ACK edge
// WAIT_RELEASE | ACK seen, waiting for both lines to return high
module ps2_command_tx #(
  parameter int CLK_INHIBIT_CYCLES   = 5000,
  parameter int START_TIMEOUT_CYCLES = 750000,
  parameter int BIT_TIMEOUT_CYCLES   = 100000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] command,
  input  logic       send_command,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_drive_low,
  output logic       ps2_dat_drive_low,
  output logic       busy,
  output logic       command_was_sent,
  output logic       error_timed_out,
  output logic       error_no_ack
);

  localparam int MAX_A      = (CLK_INHIBIT_CYCLES > START_TIMEOUT_CYCLES) ?
                              CLK_INHIBIT_CYCLES : START_TIMEOUT_CYCLES;
  localparam int MAX_CYCLES = (MAX_A > BIT_TIMEOUT_CYCLES) ? MAX_A : BIT_TIMEOUT_CYCLES;
  localparam int TW         = $clog2(MAX_CYCLES + 1);

  localparam logic [TW-1:0] INHIBIT_LOAD = TW'(CLK_INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] START_LOAD   = TW'(START_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] BIT_LOAD     = TW'(BIT_TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, RTS, WAIT_FIRST, SHIFT, WAIT_ACK, WAIT_RELEASE
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [9:0]    frame_q, frame_d;
  logic [3:0]    idx_q, idx_d;
  logic          clk_low_q, clk_low_d;
  logic          dat_low_q, dat_low_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          tmo_q, tmo_d;
  logic          noack_q, noack_d;

  logic clk_meta_q, clk_sync_q, clk_prev_q;
  logic dat_meta_q, dat_sync_q;
  logic fall, tc, pulse_any;

  assign fall      = clk_prev_q & ~clk_sync_q;
  assign tc        = (timer_q == '0);
  assign pulse_any = done_q | tmo_q | noack_q;

  always_comb begin
    state_d   = state_q;
    timer_d   = tc ? '0 : timer_q - TW'(1);
    frame_d   = frame_q;
    idx_d     = idx_q;
    clk_low_d = 1'b0;
    dat_low_d = dat_low_q;
    done_d    = 1'b0;
    tmo_d     = 1'b0;
    noack_d   = 1'b0;

    case (state_q)
      IDLE: begin
        dat_low_d = 1'b0;
        // a strobe coinciding with a completion pulse is dropped
        if (send_command && !pulse_any) begin
          frame_d   = {1'b1, ~^command, command};
          idx_d     = 4'd0;
          timer_d   = INHIBIT_LOAD;
          clk_low_d = 1'b1;
          state_d   = INHIBIT;
        end
      end
      INHIBIT: begin
        clk_low_d = 1'b1;
        if (tc) begin
          dat_low_d = 1'b1;
          state_d   = RTS;
        end
      end
      RTS: begin
        dat_low_d = 1'b1;
        timer_d   = START_LOAD;
        state_d   = WAIT_FIRST;
      end
      WAIT_FIRST: begin
        if (fall) begin
          dat_low_d = ~frame_q[0];
          idx_d     = 4'd1;
          timer_d   = BIT_LOAD;
          state_d   = SHIFT;
        end else if (tc) begin
          dat_low_d = 1'b0;
          tmo_d     = 1'b1;
          state_d   = IDLE;
        end
      end
      SHIFT: begin
        if (fall) begin
          dat_low_d = ~frame_q[idx_q];
          idx_d     = idx_q + 4'd1;
          timer_d   = BIT_LOAD;
          if (idx_q == 4'd9) state_d = WAIT_ACK;
        end else if (tc) begin
          dat_low_d = 1'b0;
          tmo_d     = 1'b1;
          state_d   = IDLE;
        end
      end
      WAIT_ACK: begin
        if (fall) begin
          if (!dat_sync_q) begin
            timer_d = BIT_LOAD;
            state_d = WAIT_RELEASE;
          end else begin
            dat_low_d = 1'b0;
            noack_d   = 1'b1;
            state_d   = IDLE;
          end
        end else if (tc) begin
          dat_low_d = 1'b0;
          tmo_d     = 1'b1;
          state_d   = IDLE;
        end
      end
      WAIT_RELEASE: begin
        if (clk_sync_q && dat_sync_q) begin
          dat_low_d = 1'b0;
          done_d    = 1'b1;
          state_d   = IDLE;
        end else if (tc) begin
          dat_low_d = 1'b0;
          tmo_d     = 1'b1;
          state_d   = IDLE;
        end
      end
      default: begin
        dat_low_d = 1'b0;
        state_d   = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      frame_q    <= '0;
      idx_q      <= '0;
      clk_low_q  <= 1'b0;
      dat_low_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tmo_q      <= 1'b0;
      noack_q    <= 1'b0;
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      frame_q    <= frame_d;
      idx_q      <= idx_d;
      clk_low_q  <= clk_low_d;
      dat_low_q  <= dat_low_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tmo_q      <= tmo_d;
      noack_q    <= noack_d;
      clk_meta_q <= ps2_clk_in;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      dat_meta_q <= ps2_dat_in;
      dat_sync_q <= dat_meta_q;
    end
  end

  assign ps2_clk_drive_low = clk_low_q;
  assign ps2_dat_drive_low = dat_low_q;
  assign busy              = busy_q;
  assign command_was_sent  = done_q;
  assign error_timed_out   = tmo_q;
  assign error_no_ack      = noack_q;

endmodule

// File: tb/tb_ps2_command_tx.sv
// Bench for ps2_command_tx: PS/2 device model on the open-drain lines, expectation queue and
// a monitor that checks each completion/error pulse against the queued expectation.
module tb_ps2_command_tx;

  localparam int INH = 20;
  localparam int STO = 400;
  localparam int BTO = 200;
  localparam int K_DONE  = 0;
  localparam int K_TMO   = 1;
  localparam int K_NOACK = 2;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] command = 8'h00;
  logic       send_command = 1'b0;
  logic       host_clk_low, host_dat_low;
  logic       busy, done, tmo, noack;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       clk_line, dat_line;

  assign clk_line = ~(host_clk_low | dev_clk_low);
  assign dat_line = ~(host_dat_low | dev_dat_low);

  ps2_command_tx #(
    .CLK_INHIBIT_CYCLES  (INH),
    .START_TIMEOUT_CYCLES(STO),
    .BIT_TIMEOUT_CYCLES  (BTO)
  ) dut (
    .CLOCK_50         (CLOCK_50),
    .reset            (reset),
    .command          (command),
    .send_command     (send_command),
    .ps2_clk_in       (clk_line),
    .ps2_dat_in       (dat_line),
    .ps2_clk_drive_low(host_clk_low),
    .ps2_dat_drive_low(host_dat_low),
    .busy             (busy),
    .command_was_sent (done),
    .error_timed_out  (tmo),
    .error_no_ack     (noack)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  typedef struct {
    int          kind;
    logic [10:0] bits;
    int          exp_cyc;
    bit          use_fall;
  } exp_t;

  exp_t        exp_q[$];
  logic [10:0] cap_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  int bfm_mode   = 0;   // 0 normal, 1 never clocks, 2 stops after bfm_stop_n falls, 3 no ACK
  int bfm_stop_n = 5;
  int bfm_fall_cyc = 0;

  task automatic check_eq(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Line image seen by the device: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] ref_frame(input logic [7:0] b);
    int ones;
    logic [10:0] f;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ones += int'(b[i]);
      f[i+1] = b[i];
    end
    f[9]  = ((ones % 2) == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic bfm_wait(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  initial begin : bfm
    logic [10:0] cap;
    bit stopped;
    cap = '0;
    forever begin
      bfm_wait(1);
      if (busy && !host_clk_low && host_dat_low) begin
        if (bfm_mode != 1) begin
          bfm_wait(10);
          cap[0]  = dat_line;
          stopped = 1'b0;
          for (int k = 1; k <= 10 && !stopped; k++) begin
            dev_clk_low  = 1'b1;
            bfm_fall_cyc = cyc;
            bfm_wait(20);
            dev_clk_low = 1'b0;
            cap[k] = dat_line;
            bfm_wait(20);
            if (bfm_mode == 2 && k == bfm_stop_n) stopped = 1'b1;
          end
          if (!stopped) begin
            cap_q.push_back(cap);
            if (bfm_mode != 3) dev_dat_low = 1'b1;
            bfm_wait(10);
            dev_clk_low = 1'b1;
            bfm_wait(20);
            dev_clk_low = 1'b0;
            bfm_wait(10);
            dev_dat_low = 1'b0;
          end
        end
        while (busy) bfm_wait(1);
      end
    end
  end

  initial begin : monitor
    exp_t e;
    int   kind;
    forever begin
      @(negedge CLOCK_50);
      if (!reset && (done || tmo || noack)) begin
        kind = done ? K_DONE : (tmo ? K_TMO : K_NOACK);
        check_eq("pulse_onehot", int'(done) + int'(tmo) + int'(noack), 1);
        check_eq("busy_at_pulse", int'(busy), 0);
        check_eq("lines_released", int'(host_clk_low | host_dat_low), 0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pulse: got kind %0d, expected no pulse (cycle %0d)", kind, cyc);
        end else begin
          e = exp_q.pop_front();
          check_eq("pulse_kind", kind, e.kind);
          if (e.kind != K_TMO) begin
            if (cap_q.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL frame_bits: got no captured frame, expected %0h", e.bits);
            end else begin
              check_eq("frame_bits", int'(cap_q.pop_front()), int'(e.bits));
            end
          end
          if (e.exp_cyc >= 0) check_eq("start_timeout_cycle", cyc, e.exp_cyc);
          if (e.use_fall) check_eq("bit_timeout_cycle", cyc, bfm_fall_cyc + 3 + BTO);
        end
      end
    end
  end

  // Each host clock-low run must be INH inhibit cycles plus one RTS cycle with dat low.
  initial begin : inhibit_check
    int run, dlow;
    run = 0;
    dlow = 0;
    forever begin
      @(negedge CLOCK_50);
      if (reset) begin
        run = 0;
        dlow = 0;
      end else if (host_clk_low) begin
        run++;
        if (host_dat_low) dlow++;
      end else if (run > 0) begin
        check_eq("inhibit_rts_len", run, INH + 1);
        check_eq("rts_dat_low_cycles", dlow, 1);
        run = 0;
        dlow = 0;
      end
    end
  end

  task automatic push_exp(input int kind, input logic [7:0] b, input int exp_cyc, input bit use_fall);
    exp_t e;
    e.kind     = kind;
    e.bits     = ref_frame(b);
    e.exp_cyc  = exp_cyc;
    e.use_fall = use_fall;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] b, output int acc);
    @(negedge CLOCK_50);
    command      = b;
    send_command = 1'b1;
    acc          = cyc + 1;
    @(negedge CLOCK_50);
    send_command = 1'b0;
    command      = 8'($urandom);
  endtask

  task automatic wait_pulse(input string name);
    int n;
    n = 0;
    while (!(done || tmo || noack) && n < 3000) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (n >= 3000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got no pulse within 3000 cycles, expected one", name);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int acc;
    logic [7:0] b;
    acc = 0;

    idle(5);
    check_eq("rst_clk_low", int'(host_clk_low), 0);
    check_eq("rst_dat_low", int'(host_dat_low), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_tmo", int'(tmo), 0);
    check_eq("rst_noack", int'(noack), 0);
    reset = 1'b0;
    idle(5);

    // device chatter while idle must not start anything
    repeat (3) begin
      @(negedge CLOCK_50) dev_clk_low = 1'b1;
      idle(6);
      dev_clk_low = 1'b0;
      idle(6);
    end
    check_eq("idle_chatter_busy", int'(busy), 0);

    bfm_mode = 0;
    push_exp(K_DONE, 8'hED, -1, 1'b0);
    send(8'hED, acc);
    wait_pulse("t1_ed");
    idle(10);

    push_exp(K_DONE, 8'hF4, -1, 1'b0);
    send(8'hF4, acc);
    wait_pulse("t2_f4");
    // strobe held from the pulse cycle: dropped there, taken one cycle later
    push_exp(K_DONE, 8'hFF, -1, 1'b0);
    command      = 8'hFF;
    send_command = 1'b1;
    @(negedge CLOCK_50);
    check_eq("send_in_pulse_cycle_ignored", int'(busy), 0);
    @(negedge CLOCK_50);
    check_eq("send_after_pulse_accepted", int'(busy), 1);
    send_command = 1'b0;
    wait_pulse("t2_ff");
    idle(10);

    bfm_mode = 1;
    b = 8'($urandom);
    send(b, acc);
    push_exp(K_TMO, b, acc + INH + 1 + STO, 1'b0);
    wait_pulse("t3_start_timeout");
    idle(10);

    bfm_mode = 2;
    bfm_stop_n = 5;
    push_exp(K_TMO, 8'h00, -1, 1'b1);
    send(8'($urandom), acc);
    wait_pulse("t4_bit_timeout");
    idle(10);

    bfm_mode = 3;
    push_exp(K_NOACK, 8'hF4, -1, 1'b0);
    send(8'hF4, acc);
    wait_pulse("t4_no_ack");
    idle(60);

    bfm_mode = 0;
    push_exp(K_DONE, 8'hED, -1, 1'b0);
    send(8'hED, acc);
    idle(150);
    check_eq("midframe_busy", int'(busy), 1);
    command      = 8'h00;
    send_command = 1'b1;
    @(negedge CLOCK_50);
    send_command = 1'b0;
    command      = 8'h5A;
    wait_pulse("t5_ignored_send");
    idle(10);

    bfm_mode = 2;
    bfm_stop_n = 3;
    send(8'($urandom), acc);
    idle(120);
    check_eq("pre_reset_busy", int'(busy), 1);
    reset = 1'b1;
    @(negedge CLOCK_50);
    check_eq("midreset_clk_low", int'(host_clk_low), 0);
    check_eq("midreset_dat_low", int'(host_dat_low), 0);
    check_eq("midreset_busy", int'(busy), 0);
    check_eq("midreset_pulses", int'(done | tmo | noack), 0);
    reset = 1'b0;
    idle(100);
    bfm_mode = 0;
    push_exp(K_DONE, 8'hF4, -1, 1'b0);
    send(8'hF4, acc);
    wait_pulse("t6_after_reset");
    idle(10);

    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      bfm_mode = ($urandom_range(0, 3) == 0) ? 3 : 0;
      push_exp((bfm_mode == 3) ? K_NOACK : K_DONE, b, -1, 1'b0);
      send(b, acc);
      wait_pulse("rand_txn");
      idle(60);
    end

    check_eq("exp_queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
